// File: rtl/ht1632_serial_tx.sv
// ht1632_serial_tx
//   Serial write engine for a chain of HT1632 LED driver panels. After reset
//   it sends the seven panel init commands to every panel, then accepts
//   frames (right-aligned payload, MSB first) on a valid/ready handshake and
//   bit-bangs them on the cs_n / wr_n / data bus. The last accepted frame can
//   be resent periodically (auto refresh).
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   frame_data       : payload, bit frame_nbits-1 goes out first
//   frame_nbits      : frame length, clamped to MAX_BITS
//   frame_cs         : panel select mask (1 = selected)
//   frame_valid/ready: request handshake
//   auto_refresh_en  : periodic resend of the last accepted frame
//   init_done        : init command sequence finished
//   busy             : engine not idle
//   cs_n, wr_n, data : HT1632 serial bus
//
// MAX_BITS must be at least 12 (the init command length).
module ht1632_serial_tx #(
   parameter int MAX_BITS       = 394,
   parameter int NUM_CS         = 4,
   parameter int CLK_DIV        = 4,
   parameter int REFRESH_CYCLES = 100000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [MAX_BITS-1:0] frame_data,
   input  logic [15:0]         frame_nbits,
   input  logic [NUM_CS-1:0]   frame_cs,
   input  logic                frame_valid,
   output logic                frame_ready,
   input  logic                auto_refresh_en,
   output logic                init_done,
   output logic                busy,
   output logic [NUM_CS-1:0]   cs_n,
   output logic                wr_n,
   output logic                data
);

   localparam int IDX_W = $clog2(MAX_BITS);
   localparam int NB_W  = $clog2(MAX_BITS + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RC_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(REFRESH_CYCLES - 1);
   localparam logic [NB_W-1:0]  NB_MAX   = NB_W'(MAX_BITS);
   localparam logic [NB_W-1:0]  NB_INIT  = NB_W'(12);
   localparam logic [IDX_W-1:0] IDX_INIT = IDX_W'(11);
   localparam logic [2:0]       LAST_CMD = 3'd6;

   typedef enum logic [2:0] {
      INIT_LOAD, IDLE, LOAD, CS_SETUP, BIT_LO, BIT_HI, CS_HOLD, GAP
   } state_t;

   state_t              state_q, state_d;
   logic [DIV_W-1:0]    div_q, div_d;
   logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
   logic [2:0]          cmd_idx_q, cmd_idx_d;
   logic                init_done_q, init_done_d;
   logic [MAX_BITS-1:0] sh_data_q, sh_data_d;
   logic [NB_W-1:0]     sh_nbits_q, sh_nbits_d;
   logic [NUM_CS-1:0]   sh_cs_q, sh_cs_d;
   logic                sh_valid_q, sh_valid_d;
   logic [RC_W-1:0]     cnt_q, cnt_d;
   logic                pend_q, pend_d;

   logic [7:0]      init_cmd;
   logic [NB_W-1:0] nbits_clamp;
   logic            hs, tick, cnt_en, wrap;

   always_comb begin
      case (cmd_idx_q)
         3'd0:    init_cmd = 8'h01;
         3'd1:    init_cmd = 8'h03;
         3'd2:    init_cmd = 8'h08;
         3'd3:    init_cmd = 8'h14;
         3'd4:    init_cmd = 8'h18;
         3'd5:    init_cmd = 8'h24;
         default: init_cmd = 8'hAF;
      endcase
   end

   assign nbits_clamp = (frame_nbits > 16'(MAX_BITS)) ? NB_MAX : frame_nbits[NB_W-1:0];
   assign hs          = frame_valid && frame_ready;
   assign tick        = (div_q == DIV_LAST);
   assign cnt_en      = init_done_q && auto_refresh_en && sh_valid_q;
   assign wrap        = cnt_en && (cnt_q == RC_LAST);

   always_comb begin
      state_d     = state_q;
      div_d       = '0;
      bit_idx_d   = bit_idx_q;
      cmd_idx_d   = cmd_idx_q;
      init_done_d = init_done_q;
      sh_data_d   = sh_data_q;
      sh_nbits_d  = sh_nbits_q;
      sh_cs_d     = sh_cs_q;
      sh_valid_d  = sh_valid_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;

      // Refresh timer keeps running while a frame is on the bus; a wrap
      // that cannot be serviced right away is remembered in pend.
      if (!auto_refresh_en || hs) cnt_d = '0;
      else if (cnt_en)            cnt_d = wrap ? '0 : cnt_q + RC_W'(1);
      if (wrap && state_q != IDLE) pend_d = 1'b1;

      case (state_q)
         INIT_LOAD: begin
            // Init commands reuse the shadow register; shadow-valid stays
            // low, so nothing is refreshed from it.
            sh_data_d  = MAX_BITS'({3'b100, init_cmd, 1'b0});
            sh_nbits_d = NB_INIT;
            sh_cs_d    = '1;
            bit_idx_d  = IDX_INIT;
            state_d    = CS_SETUP;
         end
         IDLE: begin
            if (hs) begin
               sh_data_d  = frame_data;
               sh_nbits_d = nbits_clamp;
               sh_cs_d    = frame_cs;
               sh_valid_d = 1'b1;
               pend_d     = 1'b0;
               state_d    = LOAD;
            end else if (wrap || (pend_q && auto_refresh_en)) begin
               pend_d  = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            if (sh_nbits_q == '0 || sh_cs_q == '0) begin
               state_d = IDLE;
            end else begin
               bit_idx_d = IDX_W'(sh_nbits_q - NB_W'(1));
               state_d   = CS_SETUP;
            end
         end
         CS_SETUP: begin
            if (tick) state_d = BIT_LO;
            else      div_d   = div_q + DIV_W'(1);
         end
         BIT_LO: begin
            if (tick) state_d = BIT_HI;
            else      div_d   = div_q + DIV_W'(1);
         end
         BIT_HI: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else if (bit_idx_q == '0) begin
               state_d = CS_HOLD;
            end else begin
               bit_idx_d = bit_idx_q - IDX_W'(1);
               state_d   = BIT_LO;
            end
         end
         CS_HOLD: begin
            if (tick) state_d = GAP;
            else      div_d   = div_q + DIV_W'(1);
         end
         GAP: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else if (init_done_q) begin
               state_d = IDLE;
            end else if (cmd_idx_q == LAST_CMD) begin
               init_done_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cmd_idx_d = cmd_idx_q + 3'd1;
               state_d   = INIT_LOAD;
            end
         end
         default: state_d = INIT_LOAD;
      endcase

      if (!auto_refresh_en) pend_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= INIT_LOAD;
         div_q       <= '0;
         bit_idx_q   <= '0;
         cmd_idx_q   <= '0;
         init_done_q <= 1'b0;
         sh_data_q   <= '0;
         sh_nbits_q  <= '0;
         sh_cs_q     <= '0;
         sh_valid_q  <= 1'b0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         bit_idx_q   <= bit_idx_d;
         cmd_idx_q   <= cmd_idx_d;
         init_done_q <= init_done_d;
         sh_data_q   <= sh_data_d;
         sh_nbits_q  <= sh_nbits_d;
         sh_cs_q     <= sh_cs_d;
         sh_valid_q  <= sh_valid_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
      end
   end

   // Bus pins decode straight from the state flops so reset idles them
   // in the same cycle it is asserted.
   logic on_bus;
   assign on_bus      = (state_q == CS_SETUP) || (state_q == BIT_LO) ||
                        (state_q == BIT_HI)   || (state_q == CS_HOLD);
   assign cs_n        = on_bus ? ~sh_cs_q : '1;
   assign wr_n        = (state_q != BIT_LO);
   assign data        = ((state_q == BIT_LO) || (state_q == BIT_HI)) ? sh_data_q[bit_idx_q] : 1'b0;
   assign busy        = (state_q != IDLE);
   assign frame_ready = (state_q == IDLE) && init_done_q;
   assign init_done   = init_done_q;

endmodule

// File: tb/tb_ht1632_serial_tx.sv
// Bench for ht1632_serial_tx: a bus monitor reconstructs each cs_n-low
// window (bits latched on wr_n rising edges, select mask, low time, start
// and stop cycle); tests compare those records with values derived from the
// frame rules (MSB-first from nbits-1, clamp, CLK_DIV*(2N+2) low time).
module tb_ht1632_serial_tx;
   localparam int MB  = 394;
   localparam int NCS = 4;
   localparam int CD  = 2;
   localparam int RC  = 1000;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [MB-1:0]  frame_data = '0;
   logic [15:0]    frame_nbits = '0;
   logic [NCS-1:0] frame_cs = '0;
   logic           frame_valid = 1'b0;
   logic           auto_refresh_en = 1'b0;
   logic           frame_ready, init_done, busy, wr_n, data;
   logic [NCS-1:0] cs_n;

   ht1632_serial_tx #(.MAX_BITS(MB), .NUM_CS(NCS), .CLK_DIV(CD), .REFRESH_CYCLES(RC)) dut (
      .clk(clk), .rst_n(rst_n), .frame_data(frame_data), .frame_nbits(frame_nbits),
      .frame_cs(frame_cs), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .auto_refresh_en(auto_refresh_en), .init_done(init_done), .busy(busy),
      .cs_n(cs_n), .wr_n(wr_n), .data(data));

   always #5 clk = ~clk;

   typedef struct {
      logic [MB-1:0]  bits;
      int             n;
      logic [NCS-1:0] cs;
      int             low;
      int             start;
      int             stop;
      bit             cs_stable;
   } frm_t;

   typedef struct {
      logic [MB-1:0]  d;
      int             nbits;
      logic [NCS-1:0] cs;
      int             exp_n;
      int             exp_low;
   } vec_t;

   frm_t           mon_q[$];
   int             cyc = 0;
   bit             in_frame = 0;
   logic [MB-1:0]  cur_bits;
   int             cur_n = 0, cur_low = 0, cur_start = 0;
   logic [NCS-1:0] cur_cs;
   bit             cur_stable;
   logic           prev_wr = 1'b1, prev_rdy = 1'b0, prev_init = 1'b0;
   int             stray = 0, rdy_rise_cyc = -1, init_rise_cyc = -1;
   int             n_chk = 0, n_pass = 0, hs_tick = 0;

   // Bus monitor, sampling on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!prev_wr && wr_n && (cs_n == '1 || !rst_n)) stray++;
         if (cs_n != '1) begin
            if (!in_frame) begin
               in_frame = 1; cur_bits = '0; cur_n = 0; cur_cs = ~cs_n;
               cur_low = 0; cur_start = cyc; cur_stable = 1;
            end
            if ((~cs_n) != cur_cs) cur_stable = 0;
            cur_low++;
            if (!prev_wr && wr_n) begin
               cur_bits = {cur_bits[MB-2:0], data};
               cur_n++;
            end
         end else if (in_frame) begin
            in_frame = 0;
            mon_q.push_back('{cur_bits, cur_n, cur_cs, cur_low, cur_start, cyc, cur_stable});
         end
         if (frame_ready && !prev_rdy) rdy_rise_cyc = cyc;
         if (init_done && !prev_init) init_rise_cyc = cyc;
         prev_wr = wr_n; prev_rdy = frame_ready; prev_init = init_done;
      end
   end

   task automatic tick();
      @(negedge clk); #1;
   endtask

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_vec(input string name, input logic [MB-1:0] act, input logic [MB-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [MB-1:0] lowmask(input int n);
      logic [MB-1:0] m;
      for (int i = 0; i < MB; i++) m[i] = (i < n);
      return m;
   endfunction

   function automatic logic [MB-1:0] rand_data();
      logic [MB-1:0] r;
      for (int i = 0; i < MB; i++) r[i] = 1'($urandom_range(0, 1));
      return r;
   endfunction

   function automatic frm_t take();
      frm_t f;
      f = '{'0, -1, '0, -1, -1, -1, 0};
      if (mon_q.size() > 0) f = mon_q.pop_front();
      return f;
   endfunction

   function automatic vec_t mkv(input logic [MB-1:0] d, input int nb, input logic [NCS-1:0] cs,
                                input int en, input int el);
      vec_t v;
      v.d = d; v.nbits = nb; v.cs = cs; v.exp_n = en; v.exp_low = el;
      return v;
   endfunction

   task automatic wait_frames(input int k, input int budget, input string name);
      int i = 0;
      while (mon_q.size() < k && i < budget) begin tick(); i++; end
      chk(name, mon_q.size(), k);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   task automatic wait_ready(input string name);
      int i = 0;
      while (!frame_ready && i < 5000) begin tick(); i++; end
      chk(name, frame_ready, 1);
   endtask

   task automatic send(input logic [MB-1:0] d, input int nb, input logic [NCS-1:0] cs);
      wait_ready("send_ready");
      frame_data = d; frame_nbits = 16'(nb); frame_cs = cs; frame_valid = 1'b1;
      hs_tick = cyc;
      tick();
      frame_valid = 1'b0;
   endtask

   task automatic check_frame(input string tag, input frm_t f, input logic [MB-1:0] d,
                              input int n, input logic [NCS-1:0] cs, input int low);
      chk({tag, ".nbits"}, f.n, n);
      chk_vec({tag, ".bits"}, f.bits, d & lowmask(n));
      chk({tag, ".cs"}, f.cs, cs);
      chk({tag, ".cs_low"}, f.low, low);
      chk({tag, ".cs_stable"}, f.cs_stable, 1);
   endtask

   task automatic check_init();
      logic [7:0]    cmds [7];
      logic [MB-1:0] e;
      frm_t          f;
      int            last_stop;
      int            i;
      cmds = '{8'h01, 8'h03, 8'h08, 8'h14, 8'h18, 8'h24, 8'hAF};
      wait_frames(7, 1000, "init_frames");
      chk("init_done_before_gap", init_done, 0);
      last_stop = (mon_q.size() > 0) ? mon_q[mon_q.size()-1].stop : -1;
      i = 0;
      while (!init_done && i < 50) begin tick(); i++; end
      chk("init_done_delay", init_rise_cyc - last_stop, CD);
      chk("init_ready", frame_ready, 1);
      for (int k = 0; k < 7; k++) begin
         f = take();
         e = '0;
         e[11:0] = {3'b100, cmds[k], 1'b0};
         check_frame($sformatf("init%0d", k), f, e, 12, 4'hF, CD * 26);
      end
   endtask

   initial begin
      vec_t          vt[9];
      logic [MB-1:0] pat, d, d2;
      logic [7:0]    a5;
      frm_t          f;
      int            nb, t0, i;
      logic [NCS-1:0] cs;
      int            exp_start[5];
      logic [MB-1:0] exp_bits[5];

      // reset state
      tick();
      chk("rst_cs_n", cs_n, 4'hF);
      chk("rst_wr_n", wr_n, 1);
      chk("rst_data", data, 0);
      chk("rst_ready", frame_ready, 0);
      chk("rst_busy", busy, 1);
      chk("rst_init_done", init_done, 0);
      tick();
      rst_n = 1'b1;

      check_init();

      // table-driven frames
      a5 = 8'hA5;
      for (int k = 0; k < MB; k++) pat[k] = a5[k % 8];
      vt[0] = mkv(pat,          394,   4'b0010, 394, 1580);
      vt[1] = mkv(rand_data(),  500,   4'b1111, 394, 1580);
      vt[2] = mkv(rand_data(),  0,     4'b0101, 0,   0);
      vt[3] = mkv(rand_data(),  10,    4'b0000, 0,   0);
      vt[4] = mkv(rand_data(),  1,     4'b1000, 1,   8);
      vt[5] = mkv(rand_data(),  12,    4'b1010, 12,  52);
      vt[6] = mkv(rand_data(),  37,    4'b0110, 37,  152);
      vt[7] = mkv(rand_data(),  393,   4'b0001, 393, 1576);
      vt[8] = mkv('1,           65535, 4'b0100, 394, 1580);
      for (int k = 0; k < 9; k++) begin
         send(vt[k].d, vt[k].nbits, vt[k].cs);
         if (vt[k].exp_low == 0) begin
            chk($sformatf("v%0d.ready_load", k), frame_ready, 0);
            tick();
            chk($sformatf("v%0d.ready_back", k), frame_ready, 1);
            chk($sformatf("v%0d.no_frame", k), mon_q.size() + int'(in_frame), 0);
         end else begin
            wait_frames(1, 4000, $sformatf("v%0d.seen", k));
            f = take();
            check_frame($sformatf("v%0d", k), f, vt[k].d, vt[k].exp_n, vt[k].cs, vt[k].exp_low);
            wait_ready($sformatf("v%0d.ready", k));
            chk($sformatf("v%0d.ready_delay", k), rdy_rise_cyc - f.stop, CD);
         end
      end

      // random frames against the reference rules
      for (int r = 0; r < 6; r++) begin
         d  = rand_data();
         nb = int'($urandom_range(1, 60));
         cs = 4'($urandom_range(1, 15));
         send(d, nb, cs);
         wait_frames(1, 1000, "rand.seen");
         f = take();
         check_frame($sformatf("rand%0d", r), f, d, (nb > MB) ? MB : nb, cs, CD * (2 * nb + 2));
      end

      // input data changed while the frame is in flight
      d = rand_data();
      send(d, 200, 4'b1001);
      repeat (100) tick();
      frame_data = ~d;
      wait_frames(1, 2000, "mid_change.seen");
      f = take();
      check_frame("mid_change", f, d, 200, 4'b1001, CD * 402);

      // periodic refresh, and a new frame on the wrap cycle
      wait_ready("refresh.ready");
      d  = rand_data();
      d2 = rand_data();
      auto_refresh_en = 1'b1;
      send(d, 8, 4'b0001);
      t0 = hs_tick;
      wait_until(t0 + 3000);
      chk("refresh.ready_at_wrap", frame_ready, 1);
      frame_data = d2; frame_nbits = 16'd8; frame_cs = 4'b0001; frame_valid = 1'b1;
      tick();
      frame_valid = 1'b0;
      wait_until(t0 + 4500);
      auto_refresh_en = 1'b0;
      wait_until(t0 + 6500);
      chk("refresh.count", mon_q.size(), 5);
      exp_start = '{2, 1002, 2002, 3002, 4002};
      exp_bits  = '{d, d, d, d2, d2};
      for (int k = 0; k < 5; k++) begin
         f = take();
         chk($sformatf("refresh%0d.start", k), f.start - t0, exp_start[k]);
         check_frame($sformatf("refresh%0d", k), f, exp_bits[k], 8, 4'b0001, CD * 18);
      end

      // wrap while busy: resend starts on the first idle cycle
      d = rand_data();
      auto_refresh_en = 1'b1;
      send(d, 300, 4'b0011);
      t0 = hs_tick;
      wait_until(t0 + 1500);
      auto_refresh_en = 1'b0;
      wait_until(t0 + 4000);
      chk("pend.count", mon_q.size(), 2);
      f = take();
      chk("pend0.start", f.start - t0, 2);
      check_frame("pend0", f, d, 300, 4'b0011, CD * 602);
      f = take();
      chk("pend1.start", f.start - t0, 2 + 2 + CD * (2 * 300 + 3));
      check_frame("pend1", f, d, 300, 4'b0011, CD * 602);

      // reset in the middle of a long frame
      d = rand_data();
      send(d, 394, 4'hF);
      i = 0;
      while (!(in_frame && cur_n == 100) && i < 3000) begin tick(); i++; end
      chk("abort.at_bit", cur_n, 100);
      rst_n = 1'b0;
      #1;
      chk("abort.cs_n", cs_n, 4'hF);
      chk("abort.wr_n", wr_n, 1);
      chk("abort.data", data, 0);
      chk("abort.ready", frame_ready, 0);
      chk("abort.busy", busy, 1);
      chk("abort.init_done", init_done, 0);
      repeat (4) tick();
      rst_n = 1'b1;
      tick();
      chk("abort.frames", mon_q.size(), 1);
      f = take();
      chk("abort.nbits", f.n, 100);
      chk_vec("abort.bits", f.bits, (d >> 294) & lowmask(100));
      check_init();
      chk("stray_wr_edges", stray, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
